// File: rtl/sseg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// sseg_scan_ctrl
//
// Scan controller for a 4-digit common-anode 7-segment display.
// Each digit gets a slot of SCAN_DIV clocks. The first GUARD clocks of every
// slot keep all digits dark to prevent ghosting. Values written with `load`
// wait in a shadow register. They move to the displayed (active) register
// only at the end of digit 3's slot, so a frame never mixes old and new data.
//
// Optional build macro: SSEG_DIM_EN
//   When defined, the module adds the `bright` input and a free-running 4-bit
//   PWM counter. An enabled digit is lit only while pwm <= bright.
//   When undefined, every enabled digit stays lit for its whole slot. This is
//   the same behaviour as bright = 15.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   din[15:0]   in   hex value, din[3:0] = digit 0 (rightmost)
//   dp_in[3:0]  in   per-digit decimal point, 1 = lit
//   blank_in[3:0] in per-digit blank, 1 = digit dark
//   load        in   1-cycle strobe capturing din/dp_in/blank_in
//   bright[3:0] in   (SSEG_DIM_EN only) brightness, 15 = full on
//   pending     out  shadow holds data not yet committed
//   frame_tick  out  1-cycle pulse in the cycle after each commit point
//   sseg[7:0]   out  active-low segments {dp,g,f,e,d,c,b,a}
//   en_dig[3:0] out  active-low digit enables
// ---------------------------------------------------------------------------
module sseg_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic        load,
`ifdef SSEG_DIM_EN
  input  logic [3:0]  bright,
`endif
  output logic        pending,
  output logic        frame_tick,
  output logic [7:0]  sseg,
  output logic [3:0]  en_dig
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Hex to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] f_hex2seg(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_shadow_din;
  logic [3:0]       r_shadow_dp;
  logic [3:0]       r_shadow_blank;
  logic [15:0]      r_active_din;
  logic [3:0]       r_active_dp;
  logic [3:0]       r_active_blank;
  logic             r_pending;
  logic             r_frame_tick;
  logic [7:0]       r_sseg;
  logic [3:0]       r_en_dig;

  logic             w_tc;
  logic             w_commit;
  logic             w_guard;
  logic             w_show;
  logic             w_lit;
  logic [3:0]       w_digit;
  logic [7:0]       w_sseg_next;
  logic [3:0]       w_en_next;

  assign w_tc     = (r_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_commit = w_tc && (r_idx == 2'd3);
  assign w_guard  = (r_cnt < CNT_W'(GUARD));
  assign w_digit  = r_active_din[{r_idx, 2'b00} +: 4];
  // The digit shows a pattern when the guard has passed and the digit is not blanked.
  assign w_show   = !w_guard && !r_active_blank[r_idx];

`ifdef SSEG_DIM_EN
  logic [3:0] r_pwm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm <= 4'd0;
    end else begin
      r_pwm <= r_pwm + 4'd1;
    end
  end

  // PWM gates only the digit enable. The segment bus keeps its pattern.
  assign w_lit = w_show && (r_pwm <= bright);
`else
  assign w_lit = w_show;
`endif

  assign w_sseg_next = w_show ? {~r_active_dp[r_idx], f_hex2seg(w_digit)} : 8'hFF;

  // One-hot-low enable. Only the bit matching r_idx can go low.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_en
      assign w_en_next[gi] = ~(w_lit && (r_idx == 2'(gi)));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_idx          <= 2'd0;
      r_shadow_din   <= 16'h0000;
      r_shadow_dp    <= 4'h0;
      r_shadow_blank <= 4'h0;
      r_active_din   <= 16'h0000;
      r_active_dp    <= 4'h0;
      r_active_blank <= 4'h0;
      r_pending      <= 1'b0;
      r_frame_tick   <= 1'b0;
      r_sseg         <= 8'hFF;
      r_en_dig       <= 4'hF;
    end else begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
      if (w_tc) begin
        r_idx <= r_idx + 2'd1;
      end
      r_frame_tick <= w_commit;

      if (w_commit) begin
        r_pending <= 1'b0;
        if (load) begin
          // A load that lands on the commit point bypasses the shadow,
          // so digit 0 of the next frame already shows it.
          r_active_din   <= din;
          r_active_dp    <= dp_in;
          r_active_blank <= blank_in;
          r_shadow_din   <= din;
          r_shadow_dp    <= dp_in;
          r_shadow_blank <= blank_in;
        end else begin
          r_active_din   <= r_shadow_din;
          r_active_dp    <= r_shadow_dp;
          r_active_blank <= r_shadow_blank;
        end
      end else if (load) begin
        r_shadow_din   <= din;
        r_shadow_dp    <= dp_in;
        r_shadow_blank <= blank_in;
        r_pending      <= 1'b1;
      end

      r_sseg   <= w_sseg_next;
      r_en_dig <= w_en_next;
    end
  end

  assign pending    = r_pending;
  assign frame_tick = r_frame_tick;
  assign sseg       = r_sseg;
  assign en_dig     = r_en_dig;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sseg_scan_ctrl
//
// Scoreboard bench for sseg_scan_ctrl with SCAN_DIV=8 and GUARD=2.
// A reference process runs on every clock edge. It counts elapsed clocks
// since reset and works out the slot and the position inside the slot by
// division. It then pushes the expected registered outputs into a queue.
// A separate monitor pops one entry on each falling edge and compares it
// with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_sseg_scan_ctrl;

  localparam int D = 8;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_in = 4'h0;
  logic        load = 1'b0;
  logic        pending;
  logic        frame_tick;
  logic [7:0]  sseg;
  logic [3:0]  en_dig;

  sseg_scan_ctrl #(.SCAN_DIV(D), .GUARD(G)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .load       (load),
    .pending    (pending),
    .frame_tick (frame_tick),
    .sseg       (sseg),
    .en_dig     (en_dig)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] sseg;
    logic [3:0] en;
    logic       pending;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Font table in dp-off form. Entries are indexed by the hex value.
  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model state
  int          m_t = 0;          // clocks since reset released
  logic [15:0] m_sh_din = 0, m_act_din = 0;
  logic [3:0]  m_sh_dp = 0, m_act_dp = 0;
  logic [3:0]  m_sh_bl = 0, m_act_bl = 0;
  logic        m_pend = 0;

  initial begin
    forever begin
      exp_t e;
      int   pos, slot;
      logic lit, commit;
      logic [3:0] dig;
      @(posedge clk);
      if (rst) begin
        m_t = 0;
        m_sh_din = 0; m_sh_dp = 0; m_sh_bl = 0;
        m_act_din = 0; m_act_dp = 0; m_act_bl = 0;
        m_pend = 0;
        e = '{sseg: 8'hFF, en: 4'hF, pending: 1'b0, tick: 1'b0};
      end else begin
        pos  = m_t % D;
        slot = (m_t / D) % 4;
        lit  = (pos >= G) && !m_act_bl[slot];
        dig  = 4'((m_act_din >> (4 * slot)) & 16'h000F);
        e.sseg = lit ? (m_act_dp[slot] ? (font[dig] & 8'h7F) : font[dig]) : 8'hFF;
        e.en   = lit ? ~(4'b0001 << slot) : 4'hF;
        commit = (pos == D - 1) && (slot == 3);
        e.tick = commit;
        if (commit) begin
          if (load) begin
            m_sh_din = din; m_sh_dp = dp_in; m_sh_bl = blank_in;
          end
          m_act_din = m_sh_din; m_act_dp = m_sh_dp; m_act_bl = m_sh_bl;
          m_pend = 1'b0;
        end else if (load) begin
          m_sh_din = din; m_sh_dp = dp_in; m_sh_bl = blank_in;
          m_pend = 1'b1;
        end
        e.pending = m_pend;
        m_t++;
      end
      exp_q.push_back(e);
    end
  end

  // Monitor
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (sseg !== e.sseg) begin
          errors++;
          $display("FAIL sseg t=%0t got=%h exp=%h", $time, sseg, e.sseg);
        end
        checks++;
        if (en_dig !== e.en) begin
          errors++;
          $display("FAIL en_dig t=%0t got=%b exp=%b", $time, en_dig, e.en);
        end
        checks++;
        if (pending !== e.pending) begin
          errors++;
          $display("FAIL pending t=%0t got=%b exp=%b", $time, pending, e.pending);
        end
        checks++;
        if (frame_tick !== e.tick) begin
          errors++;
          $display("FAIL frame_tick t=%0t got=%b exp=%b", $time, frame_tick, e.tick);
        end
      end
    end
  end

  // Stimulus helpers. They all start and end at posedge+2.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    din = v; dp_in = dp; blank_in = bl; load = 1'b1;
    $display("load din=%h dp=%b blank=%b at t=%0t", v, dp, bl, $time);
    step();
    load = 1'b0;
  endtask

  // Wait until the next edge samples position `pos` of slot `slot`.
  task automatic wait_slot(input int slot, input int pos);
    int n = 0;
    while (!((m_t % D == pos) && ((m_t / D) % 4 == slot)) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL wait_slot timeout got=%0d exp=<200", n);
    end
  endtask

  initial begin
    #2;
    // Reset held for three cycles
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(40);

    // 12AF with dp on digit 0
    do_load(16'h12AF, 4'b0001, 4'b0000);
    idle(80);

    // Mid-frame load while 12AF is displayed
    wait_slot(1, 4);
    do_load(16'h0000, 4'b0000, 4'b0000);
    idle(50);

    // Load exactly on the commit point
    wait_slot(3, D - 1);
    do_load(16'h8888, 4'b0000, 4'b0000);
    idle(40);

    // Blank digit 3
    do_load(16'hFFFF, 4'b0000, 4'b1000);
    idle(70);

    // Reset in the middle of digit 2's slot with pending data
    wait_slot(0, 3);
    do_load(16'h5A5A, 4'b1010, 4'b0000);
    wait_slot(2, 4);
    rst = 1'b1;
    $display("reset pulse at t=%0t", $time);
    step();
    rst = 1'b0;
    idle(40);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 29);
      if (r == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end else if (r < 4) begin
        wait_slot(3, D - 1);
        do_load(16'($urandom), 4'($urandom), 4'($urandom));
      end else begin
        idle($urandom_range(0, 20));
        do_load(16'($urandom), 4'($urandom), 4'($urandom));
      end
    end
    idle(40);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL queue_drain got=%0d exp<=1", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
